// File: rtl/core_seq_fsm_if.sv
// Sequencer-side handshake bundle: decoder inputs, imem/dmem req/ack, datapath strobes, status.
// Latency: none, wires only.
// Backpressure: the memories stall the sequencer by holding ack low.
interface core_seq_fsm_if #(
    parameter int CNT_W = 32
);
    logic             run_i;
    logic [6:0]       opcode_i;
    logic             ctrl_reg_wen_i;
    logic             imem_req_o;
    logic             imem_ack_i;
    logic             dmem_req_o;
    logic             dmem_we_o;
    logic             dmem_ack_i;
    logic             ir_wen_o;
    logic             pc_wen_o;
    logic             reg_wen_o;
    logic [2:0]       state_o;
    logic [CNT_W-1:0] instret_o;
    logic             fault_o;
    logic [1:0]       fault_cause_o;

    modport master (
        input  run_i, opcode_i, ctrl_reg_wen_i, imem_ack_i, dmem_ack_i,
        output imem_req_o, dmem_req_o, dmem_we_o, ir_wen_o, pc_wen_o, reg_wen_o,
               state_o, instret_o, fault_o, fault_cause_o
    );

    modport slave (
        output run_i, opcode_i, ctrl_reg_wen_i, imem_ack_i, dmem_ack_i,
        input  imem_req_o, dmem_req_o, dmem_we_o, ir_wen_o, pc_wen_o, reg_wen_o,
               state_o, instret_o, fault_o, fault_cause_o
    );
endinterface

// File: rtl/core_seq_fsm.sv
// Multi-cycle RV32 sequencer: FETCH/DECODE/EXEC/MEM/WB with sticky fault on timeout or bad opcode.
// Latency: 4 cycles per ALU/branch instruction, 5 for loads/stores, plus memory wait cycles.
// Backpressure: imem/dmem requests are held until ack; TIMEOUT waits without ack trap to FAULT.
module core_seq_fsm #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    core_seq_fsm_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        FAULT  = 3'd6
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam int               WCNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WCNT_W-1:0] WAIT_MAX = WCNT_W'(TIMEOUT);
    localparam bit               TO_EN    = (TIMEOUT != 0);

    state_t             state;
    state_t             nxt_state;
    logic [1:0]         nxt_cause;
    logic [WCNT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]   instret;
    logic               fault;
    logic [1:0]         fault_cause;
    logic               imem_req;
    logic               dmem_req;
    logic               dmem_we;
    logic               pc_wen;
    logic               is_legal;
    logic               is_mem;
    logic               is_store;
    logic               timed_out;

    always_comb begin
        is_legal = 1'b0;
        case (bus.opcode_i)
            OP_LOAD, OP_OPIMM, OP_AUIPC, OP_STORE, OP_OP,
            OP_LUI, OP_BRANCH, OP_JALR, OP_JAL: is_legal = 1'b1;
            default:                            is_legal = 1'b0;
        endcase
    end

    assign is_store  = (bus.opcode_i == OP_STORE);
    assign is_mem    = (bus.opcode_i == OP_LOAD) || is_store;
    // An ack in the cycle the count hits the limit is taken, so ack is checked before this.
    assign timed_out = TO_EN && (wait_cnt == WAIT_MAX);

    always_comb begin
        nxt_state = state;
        nxt_cause = 2'b00;
        case (state)
            IDLE: begin
                if (bus.run_i) nxt_state = FETCH;
            end
            FETCH: begin
                if (bus.imem_ack_i) begin
                    nxt_state = DECODE;
                end else if (timed_out) begin
                    nxt_state = FAULT;
                    nxt_cause = 2'b01;
                end
            end
            DECODE: begin
                if (is_legal) begin
                    nxt_state = EXEC;
                end else begin
                    nxt_state = FAULT;
                    nxt_cause = 2'b10;
                end
            end
            EXEC: begin
                nxt_state = is_mem ? MEM : WB;
            end
            MEM: begin
                if (bus.dmem_ack_i) begin
                    nxt_state = WB;
                end else if (timed_out) begin
                    nxt_state = FAULT;
                    nxt_cause = 2'b11;
                end
            end
            WB: begin
                nxt_state = bus.run_i ? FETCH : IDLE;
            end
            FAULT: begin
                nxt_state = FAULT;
            end
            default: begin
                nxt_state = IDLE;
            end
        endcase
    end

    // Request/strobe flops are loaded from the next state so they line up with state exactly.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            instret     <= '0;
            fault       <= 1'b0;
            fault_cause <= 2'b00;
            imem_req    <= 1'b0;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            pc_wen      <= 1'b0;
        end else begin
            state    <= nxt_state;
            imem_req <= (nxt_state == FETCH);
            dmem_req <= (nxt_state == MEM);
            dmem_we  <= (nxt_state == MEM) && is_store;
            pc_wen   <= (nxt_state == WB);
            fault    <= (nxt_state == FAULT);

            if ((nxt_state == FAULT) && (state != FAULT)) begin
                fault_cause <= nxt_cause;
            end

            if (state == WB) begin
                instret <= instret + CNT_W'(1);
            end

            if (TO_EN && (nxt_state == state) && ((state == FETCH) || (state == MEM))) begin
                wait_cnt <= wait_cnt + WCNT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    assign bus.imem_req_o    = imem_req;
    assign bus.ir_wen_o      = imem_req & bus.imem_ack_i;
    assign bus.dmem_req_o    = dmem_req;
    assign bus.dmem_we_o     = dmem_we;
    assign bus.pc_wen_o      = pc_wen;
    assign bus.reg_wen_o     = pc_wen & bus.ctrl_reg_wen_i;
    assign bus.state_o       = state;
    assign bus.instret_o     = instret;
    assign bus.fault_o       = fault;
    assign bus.fault_cause_o = fault_cause;

endmodule

// File: tb/tb_core_seq_fsm.sv
// Bench for core_seq_fsm (TIMEOUT=4, CNT_W=4): instruction-level reference model expands
// each instruction and its memory wait counts into the expected per-cycle trace.
module tb_core_seq_fsm;

    localparam int TO   = 4;
    localparam int CW   = 4;
    localparam int WRAP = 1 << CW;

    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;
    localparam logic [6:0] ADDI  = 7'b0010011;

    logic clk;
    logic rst_n;

    core_seq_fsm_if #(.CNT_W(CW)) bus ();

    core_seq_fsm #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    int exp_instret = 0;
    bit exp_fault = 1'b0;
    logic [1:0] exp_cause = 2'b00;

    logic [6:0] legal_ops [9] = '{7'b0000011, 7'b0010011, 7'b0010111, 7'b0100011, 7'b0110011,
                                  7'b0110111, 7'b1100011, 7'b1100111, 7'b1101111};

    function automatic bit op_legal(input logic [6:0] op);
        for (int i = 0; i < 9; i++) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cycle, obs, exp);
        end
    endtask

    // One clock: apply acks, compare every output at the falling edge, advance past the next rising edge.
    task automatic cyc(input bit ia, input bit da, input logic [2:0] st, input bit ireq,
                       input bit irw, input bit dreq, input bit dwe, input bit pcw, input bit rgw);
        bus.imem_ack_i = ia;
        bus.dmem_ack_i = da;
        @(negedge clk);
        chk("state",    {29'd0, bus.state_o}, {29'd0, st});
        chk("imem_req", {31'd0, bus.imem_req_o}, {31'd0, ireq});
        chk("ir_wen",   {31'd0, bus.ir_wen_o},   {31'd0, irw});
        chk("dmem_req", {31'd0, bus.dmem_req_o}, {31'd0, dreq});
        chk("dmem_we",  {31'd0, bus.dmem_we_o},  {31'd0, dwe});
        chk("pc_wen",   {31'd0, bus.pc_wen_o},   {31'd0, pcw});
        chk("reg_wen",  {31'd0, bus.reg_wen_o},  {31'd0, rgw});
        chk("fault",    {31'd0, bus.fault_o},    {31'd0, exp_fault});
        chk("cause",    {30'd0, bus.fault_cause_o}, {30'd0, exp_cause});
        chk("instret",  {28'd0, bus.instret_o},  exp_instret);
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic idle_cyc();
        cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic start();
        bus.run_i = 1'b1;
        idle_cyc();
    endtask

    // Sticky fault: random acks and run=1 must not disturb it; only reset clears it.
    task automatic fault_tail(input logic [1:0] cause);
        exp_fault = 1'b1;
        exp_cause = cause;
        bus.run_i = 1'b1;
        for (int i = 0; i < 4; i++)
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'd6,
                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        cyc(1'b0, 1'b0, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        bus.run_i = 1'b0;
        exp_fault = 1'b0;
        exp_cause = 2'b00;
        exp_instret = 0;
        idle_cyc();
    endtask

    // mode 0: run stays high; mode 1: run drops in EXEC; mode 2: reset on the 2nd MEM cycle.
    task automatic run_instr(input logic [6:0] op, input int iw, input int dw, input bit rw,
                             input int mode);
        bit is_ls, is_st, done;
        int k;
        is_st = (op == STORE);
        is_ls = (op == LOAD) || is_st;
        bus.ctrl_reg_wen_i = rw;

        done = 1'b0;
        k = 0;
        while (!done && k <= TO) begin
            if (k == iw) begin
                cyc(1'b1, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                done = 1'b1;
            end else begin
                cyc(1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            end
            k++;
        end
        if (!done) begin
            fault_tail(2'b01);
            return;
        end

        bus.opcode_i = op;
        cyc(1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        if (!op_legal(op)) begin
            fault_tail(2'b10);
            return;
        end

        if (mode == 1) bus.run_i = 1'b0;
        cyc(1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        if (is_ls) begin
            done = 1'b0;
            k = 0;
            while (!done && k <= TO) begin
                if (mode == 2 && k == 1) begin
                    rst_n = 1'b0;
                    cyc(1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 1'b1, is_st, 1'b0, 1'b0);
                    rst_n = 1'b1;
                    bus.run_i = 1'b0;
                    exp_instret = 0;
                    idle_cyc();
                    return;
                end
                if (k == dw) begin
                    cyc(1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b1, is_st, 1'b0, 1'b0);
                    done = 1'b1;
                end else begin
                    cyc(1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 1'b1, is_st, 1'b0, 1'b0);
                end
                k++;
            end
            if (!done) begin
                fault_tail(2'b11);
                return;
            end
        end

        cyc(1'b0, 1'b0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, rw);
        exp_instret = (exp_instret + 1) % WRAP;

        if (mode == 1) begin
            idle_cyc();
            idle_cyc();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        bus.run_i = 1'b0;
        bus.opcode_i = ADDI;
        bus.ctrl_reg_wen_i = 1'b0;
        bus.imem_ack_i = 1'b0;
        bus.dmem_ack_i = 1'b0;
        @(posedge clk);
        #1;
        idle_cyc();
        rst_n = 1'b1;
        idle_cyc();
        idle_cyc();

        start();
        run_instr(ADDI, 2, 0, 1'b1, 0);
        run_instr(LOAD, 0, 1, 1'b1, 0);
        run_instr(STORE, 0, 0, 1'b0, 0);
        run_instr(ADDI, TO, 0, 1'b1, 0);
        run_instr(STORE, 0, TO, 1'b0, 0);

        for (int i = 0; i < 16; i++)
            run_instr(ADDI, $urandom_range(0, 2), 0, 1'($urandom_range(0, 1)), 0);

        for (int i = 0; i < 12; i++)
            run_instr(legal_ops[$urandom_range(0, 8)], $urandom_range(0, TO),
                      $urandom_range(0, TO), 1'($urandom_range(0, 1)), 0);

        run_instr(ADDI, 1, 0, 1'b1, 1);
        start();
        run_instr(LOAD, 0, 3, 1'b1, 2);
        start();
        run_instr(7'b0000000, 0, 0, 1'b1, 0);
        start();
        run_instr(ADDI, 99, 0, 1'b1, 0);
        start();
        run_instr(LOAD, 1, 99, 1'b1, 0);
        start();
        run_instr(legal_ops[$urandom_range(0, 8)], 1, 1, 1'b1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
